keypad_encoder: RTL and testbench
=================================

// Module: keypad_encoder
// PURPOSE
//  Front end of the oven timer's digit-entry interface: scans a raw 10-key decimal
//  keypad, synchronises and debounces it, encodes the pressed key to BCD and issues
//  exactly one active-low load strobe per press. Drives the timer's data/load inputs,
//  so successive presses shift digits in (units -> tens -> minutes).
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synchronised samples required for press/release (>=1)
// PORTS
//  clk      in   1   system clock, rising edge
//  clear    in   1   reset, asynchronous, active-low
//  enablen  in   1   entry enable, active-low (high = keypad ignored, e.g. while counting)
//  keypad   in   10  raw key lines, bit i high = digit key i pressed; asynchronous, bouncy
//  data     out  4   BCD digit of last accepted key; to timer data
//  loadn    out  1   active-low one-cycle load strobe; to timer load
//  key_held out  1   high while an accepted or rejected press is still held down
// BEHAVIOUR
//  - Reset (clear low, async): state IDLE, counter 0, sync flops 0, data=4'd0,
//    loadn=1, key_held=0. Mid-operation reset aborts any press; no strobe emitted.
//  - keypad passes through a 2-flop synchroniser -> ks[9:0]; FSM acts only on ks.
//  - All outputs registered; loadn/key_held decoded from state register only.
//  - FSM:
//    IDLE:     ks!=0 and enablen=0 -> capture cap<=ks, cnt<=0, DEBOUNCE.
//    DEBOUNCE: enablen=1 or ks!=cap -> IDLE (bounce/abort). Else cnt++;
//              at cnt==DEBOUNCE_CYCLES-1 -> LOAD if cap valid, else HOLD (reject).
//    LOAD:     loadn=0 for exactly this one cycle; data<=encode(cap) on entry; -> HOLD.
//    HOLD:     key_held=1; ks==0 -> RELEASE, cnt<=0.
//    RELEASE:  key_held=1; ks!=0 -> HOLD; DEBOUNCE_CYCLES consecutive ks==0 -> IDLE.
//  - cap valid = exactly one bit set (one-hot); encode = index of set bit, 0..9.
//  - Latency: key stable before edge 1 -> ks valid after edge 2 -> DEBOUNCE after
//    edge 3 -> LOAD after edge DEBOUNCE_CYCLES+3; loadn low from edge D+3 to edge D+4
//    (D=4: low between edges 7 and 8). data valid from edge D+3, held until next LOAD.
//  - One strobe per press: holding a key never re-strobes; a new strobe needs a
//    debounced release (back through IDLE) first.
//  - Key change while held (roll-over) stays in HOLD/RELEASE; no strobe until full release.
//  - enablen rising after LOAD entry has no effect on the issued strobe; enablen is
//    not sampled in HOLD/RELEASE.
//  - cnt width = clog2(DEBOUNCE_CYCLES)+1; saturates, never wraps.
// CONFIGURATION
//  KEYPAD_PRIORITY_EN
//   undefined: multi-key cap (2+ bits set) is rejected: DEBOUNCE -> HOLD, no strobe,
//              data unchanged.
//   defined:   multi-key cap accepted; lowest-indexed set bit wins, normal LOAD.
//   Single-key behaviour identical in both builds.
// TESTING
//  1 Reset: clear=0 mid-DEBOUNCE with key 5 held -> data=0, loadn=1, key_held=0
//    immediately; release clear, keep 5 held -> one strobe D+3 edges later, data=5.
//  2 Clean press: D=4, key 7 asserted before edge 1, held 30 cycles -> loadn low
//    exactly edges 7-8, data=4'd7, no further strobe; key_held drops 6 edges after release.
//  3 Bounce: key 3 toggled every 2 cycles for 12 cycles then stable -> exactly one
//    strobe, data=3, occurring D+3 edges after last toggle.
//  4 Sequence: press/release 1, 2, 5 with 10-cycle gaps -> three strobes, data 1,2,5
//    in order; timer downstream shows 1:25.
//  5 Enable: enablen=1, press 9 -> no strobe; release, enablen=0, press 4 -> one
//    strobe, data=4.
//  6 Multi-key: keys 2 and 6 together -> without KEYPAD_PRIORITY_EN no strobe,
//    key_held=1, data unchanged; with it one strobe, data=2.

Source files
------------

// File: rtl/keypad_encoder.sv
// Keypad front end for the oven timer: synchronise, debounce, BCD-encode, one load strobe per press.
// Optional build macro KEYPAD_PRIORITY_EN: accept multi-key presses, lowest-indexed key wins.
`timescale 1ns/1ps

module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enablen,
    input  logic [9:0] keypad,
    output logic [3:0] data,
    output logic       loadn,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // The HOLD sample that saw the release already counts as the first quiet sample.
    localparam logic [CW-1:0] REL_LAST = CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        LOAD,
        HOLD,
        RELEASE
    } state_t;

    state_t        state_q;
    logic [9:0]    syncStage_q;
    logic [9:0]    ks_q;
    logic [9:0]    cap_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    data_q;

    logic [CW-1:0] cntInc_d;
    logic [3:0]    capCode_d;
    logic          capValid;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            syncStage_q <= '0;
            ks_q        <= '0;
        end else begin
            syncStage_q <= keypad;
            ks_q        <= syncStage_q;
        end
    end

    assign cntInc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Scanning downwards leaves the lowest set index as the result.
    always_comb begin
        capCode_d = '0;
        for (int i = 9; i >= 0; i--) begin
            if (cap_q[i]) begin
                capCode_d = 4'(i);
            end
        end
    end

`ifdef KEYPAD_PRIORITY_EN
    assign capValid = (cap_q != '0);
`else
    assign capValid = (cap_q != '0) && ((cap_q & (cap_q - 10'd1)) == '0);
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((ks_q != '0) && !enablen) begin
                        cap_q   <= ks_q;
                        cnt_q   <= '0;
                        state_q <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (enablen || (ks_q != cap_q)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cntInc_d;
                        if (cnt_q >= CNT_LAST) begin
                            if (capValid) begin
                                data_q  <= capCode_d;
                                state_q <= LOAD;
                            end else begin
                                state_q <= HOLD;
                            end
                        end
                    end
                end
                LOAD: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (ks_q == '0) begin
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (ks_q != '0) begin
                        state_q <= HOLD;
                    end else if (cnt_q >= REL_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cntInc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data     = data_q;
    assign loadn    = (state_q != LOAD);
    assign key_held = (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: each press pushes its expected strobe (digit, edge),
// a negedge monitor pops and compares whenever loadn goes low.
`timescale 1ns/1ps

module tb_keypad_encoder;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic       clk     = 1'b0;
    logic       clear   = 1'b1;
    logic       enablen = 1'b0;
    logic [9:0] keypad  = '0;
    logic [3:0] data;
    logic       loadn;
    logic       key_held;

    typedef struct {
        int digit;
        int edgeNum;
    } strobe_t;

    strobe_t     expQ[$];
    strobe_t     popped;
    int          cycle       = 0;
    int          checkCount  = 0;
    int          passCount   = 0;
    logic [11:0] timerDigits = '0;
    int          c;

    keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .clear    (clear),
        .enablen  (enablen),
        .keypad   (keypad),
        .data     (data),
        .loadn    (loadn),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    function automatic logic [9:0] keyBit(input int k);
        return 10'(1) << k;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press a key pattern, hold it, release it and let the release settle; expDigit < 0 means no strobe.
    task automatic applyStimulus(input logic [9:0] keys, input int holdCycles, input int gapCycles,
                                 input int expDigit);
        keypad = keys;
        if (expDigit >= 0) expQ.push_back('{digit: expDigit, edgeNum: cycle + LAT});
        waitCycles(holdCycles);
        keypad = '0;
        waitCycles(gapCycles);
    endtask

    // Strobe monitor: also models the timer shifting digits in on every load.
    always @(negedge clk) begin
        if (clear && loadn == 1'b0) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_strobe_cycle", cycle, -1);
            end else begin
                popped = expQ.pop_front();
                checkOutput("strobe_cycle", cycle, popped.edgeNum);
                checkOutput("strobe_data", int'(data), popped.digit);
            end
            timerDigits = {timerDigits[7:0], data};
        end
    end

    initial begin
        #2 clear = 1'b0;
        waitCycles(2);
        checkOutput("reset_data", int'(data), 0);
        checkOutput("reset_loadn", int'(loadn), 1);
        checkOutput("reset_key_held", int'(key_held), 0);
        clear = 1'b1;
        waitCycles(2);

        // Clean press of 7 held for 30 cycles, then timed release.
        keypad = keyBit(7);
        expQ.push_back('{digit: 7, edgeNum: cycle + LAT});
        waitCycles(10);
        checkOutput("t2_key_held", int'(key_held), 1);
        checkOutput("t2_data", int'(data), 7);
        waitCycles(20);
        keypad = '0;
        waitCycles(5);
        checkOutput("t2_held_before_release_done", int'(key_held), 1);
        waitCycles(1);
        checkOutput("t2_held_after_release", int'(key_held), 0);
        checkOutput("t2_loadn_idle", int'(loadn), 1);
        waitCycles(6);

        // Reset while key 5 is being debounced.
        keypad = keyBit(5);
        waitCycles(4);
        clear = 1'b0;
        #1;
        checkOutput("t1_reset_data", int'(data), 0);
        checkOutput("t1_reset_loadn", int'(loadn), 1);
        checkOutput("t1_reset_key_held", int'(key_held), 0);
        waitCycles(2);
        clear = 1'b1;
        expQ.push_back('{digit: 5, edgeNum: cycle + LAT});
        waitCycles(20);
        keypad = '0;
        waitCycles(10);
        checkOutput("t1_data_after", int'(data), 5);

        // Bouncing key 3, then stable.
        for (int i = 0; i < 6; i++) begin
            keypad = (i % 2 == 0) ? keyBit(3) : 10'd0;
            waitCycles(2);
        end
        applyStimulus(keyBit(3), 20, 10, 3);

        // Digit sequence 1, 2, 5 into the timer.
        timerDigits = '0;
        applyStimulus(keyBit(1), 15, 10, 1);
        applyStimulus(keyBit(2), 15, 10, 2);
        applyStimulus(keyBit(5), 15, 10, 5);
        checkOutput("t4_timer_display", int'(timerDigits), 'h125);

        // Disabled entry ignores key 9; enable toggling after LOAD has no effect.
        enablen = 1'b1;
        keypad  = keyBit(9);
        waitCycles(10);
        checkOutput("t5_disabled_key_held", int'(key_held), 0);
        checkOutput("t5_disabled_data", int'(data), 5);
        keypad = '0;
        waitCycles(5);
        enablen = 1'b0;
        keypad  = keyBit(4);
        expQ.push_back('{digit: 4, edgeNum: cycle + LAT});
        waitCycles(8);
        enablen = 1'b1;
        waitCycles(4);
        checkOutput("t5_hold_ignores_enable", int'(key_held), 1);
        keypad = '0;
        waitCycles(10);
        checkOutput("t5_released", int'(key_held), 0);
        enablen = 1'b0;
        waitCycles(2);

        // Enable pulled mid-debounce aborts; re-enabling restarts the debounce.
        keypad = keyBit(8);
        waitCycles(4);
        enablen = 1'b1;
        waitCycles(3);
        enablen = 1'b0;
        expQ.push_back('{digit: 8, edgeNum: cycle + 5});
        waitCycles(15);
        keypad = '0;
        waitCycles(10);

        // Roll-over and a short release gap must not re-strobe.
        keypad = keyBit(1);
        expQ.push_back('{digit: 1, edgeNum: cycle + LAT});
        waitCycles(12);
        keypad = keyBit(3);
        waitCycles(6);
        keypad = '0;
        waitCycles(2);
        keypad = keyBit(3);
        waitCycles(6);
        checkOutput("rollover_key_held", int'(key_held), 1);
        checkOutput("rollover_data", int'(data), 1);
        keypad = '0;
        waitCycles(10);

        // Two keys at once.
        keypad = keyBit(2) | keyBit(6);
`ifdef KEYPAD_PRIORITY_EN
        expQ.push_back('{digit: 2, edgeNum: cycle + LAT});
`endif
        waitCycles(10);
        checkOutput("t6_key_held", int'(key_held), 1);
`ifdef KEYPAD_PRIORITY_EN
        checkOutput("t6_data", int'(data), 2);
`else
        checkOutput("t6_data", int'(data), 1);
`endif
        keypad = '0;
        waitCycles(10);
        checkOutput("t6_released", int'(key_held), 0);

        waitCycles(5);
        checkOutput("pending_strobes", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
